// File: rtl/hamming_secded_codec_if.sv
// Bus bundle for the Hamming(7,4) SECDED codec: source-side inputs, encoder tap,
// decoder results and error counters.
interface hamming_secded_codec_if;
   // Valid-only flow: in_valid/code_valid/out_valid each qualify their data for
   // exactly one cycle; there is no ready, so every valid word is consumed.
   logic       in_valid;
   logic [0:3] data_in;
   logic [0:7] inject;
   logic [0:6] code_out;
   logic       parity_out;
   logic       code_valid;
   logic [0:3] data_out;
   logic       error_1bit;
   logic       error_2bit;
   logic       out_valid;
   logic [7:0] corr_count;
   logic [7:0] uncorr_count;

   modport master (
      output in_valid, data_in, inject,
      input  code_out, parity_out, code_valid, data_out,
             error_1bit, error_2bit, out_valid, corr_count, uncorr_count
   );

   modport slave (
      input  in_valid, data_in, inject,
      output code_out, parity_out, code_valid, data_out,
             error_1bit, error_2bit, out_valid, corr_count, uncorr_count
   );
endinterface

// File: rtl/hamming_secded_codec.sv
// Two-stage Hamming(7,4)+overall-parity codec: stage 1 registers the encoded word,
// stage 2 registers the corrected nibble after the error-injection XOR.
module hamming_secded_codec (
   input logic                    clk,
   input logic                    reset,
   hamming_secded_codec_if.slave  bus
);
   logic [0:6] enc_code;
   logic [0:6] code_q;
   logic       parity_q;
   logic       code_valid_q;

   logic [0:6] rc;
   logic       rp;
   logic [2:0] syn;
   logic       pc;
   logic [0:6] fixed;
   logic       dec_err1;
   logic       dec_err2;
   logic [0:3] dec_data;

   logic [0:3] data_q;
   logic       err1_q;
   logic       err2_q;
   logic       out_valid_q;
   logic [7:0] corr_q;
   logic [7:0] uncorr_q;

   // Codeword order is Hamming position order: p1 p2 d0 p4 d1 d2 d3.
   always_comb begin
      enc_code = {bus.data_in[0] ^ bus.data_in[1] ^ bus.data_in[3],
                  bus.data_in[0] ^ bus.data_in[2] ^ bus.data_in[3],
                  bus.data_in[0],
                  bus.data_in[1] ^ bus.data_in[2] ^ bus.data_in[3],
                  bus.data_in[1],
                  bus.data_in[2],
                  bus.data_in[3]};
   end

   always_comb begin
      rc       = code_q ^ bus.inject[0:6];
      rp       = parity_q ^ bus.inject[7];
      syn      = {rc[3] ^ rc[4] ^ rc[5] ^ rc[6],
                  rc[1] ^ rc[2] ^ rc[5] ^ rc[6],
                  rc[0] ^ rc[2] ^ rc[4] ^ rc[6]};
      pc       = (^rc) ^ rp;
      fixed    = rc;
      // Odd overall parity means one flip: either at position syn, or the parity bit itself.
      dec_err1 = pc;
      dec_err2 = 1'b0;
      if (syn != 3'd0) begin
         if (pc) begin
            for (int i = 0; i < 7; i++) begin
               if (syn == 3'(i + 1)) fixed[i] = ~rc[i];
            end
         end else begin
            dec_err2 = 1'b1;
         end
      end
      dec_data = {fixed[2], fixed[4], fixed[5], fixed[6]};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         code_q       <= '0;
         parity_q     <= 1'b0;
         code_valid_q <= 1'b0;
         data_q       <= '0;
         err1_q       <= 1'b0;
         err2_q       <= 1'b0;
         out_valid_q  <= 1'b0;
         corr_q       <= '0;
         uncorr_q     <= '0;
      end else begin
         code_valid_q <= bus.in_valid;
         if (bus.in_valid) begin
            code_q   <= enc_code;
            parity_q <= ^enc_code;
         end
         out_valid_q <= code_valid_q;
         if (code_valid_q) begin
            data_q <= dec_data;
            err1_q <= dec_err1;
            err2_q <= dec_err2;
            if (dec_err1 && corr_q != 8'hff) corr_q <= corr_q + 8'd1;
            if (dec_err2 && uncorr_q != 8'hff) uncorr_q <= uncorr_q + 8'd1;
         end
      end
   end

   assign bus.code_out     = code_q;
   assign bus.parity_out   = parity_q;
   assign bus.code_valid   = code_valid_q;
   assign bus.data_out     = data_q;
   assign bus.error_1bit   = err1_q;
   assign bus.error_2bit   = err2_q;
   assign bus.out_valid    = out_valid_q;
   assign bus.corr_count   = corr_q;
   assign bus.uncorr_count = uncorr_q;
endmodule

// File: tb/tb_hamming_secded_codec.sv
// Directed bench for hamming_secded_codec: clean sweep, single/parity/double errors,
// exhaustive single-flip sweep, counter saturation and mid-stream reset.
module tb_hamming_secded_codec;
   logic clk;
   logic reset;
   int   checks;
   int   errors;
   int   exp_corr;
   int   exp_uncorr;

   hamming_secded_codec_if bus ();

   hamming_secded_codec dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hand-computed codewords (p1 p2 d0 p4 d1 d2 d3) and overall parity per nibble.
   logic [0:6] code_tbl [16] = '{
      7'b0000000, 7'b1101001, 7'b0101010, 7'b1000011,
      7'b1001100, 7'b0100101, 7'b1100110, 7'b0001111,
      7'b1110000, 7'b0011001, 7'b1011010, 7'b0110011,
      7'b0111100, 7'b1010101, 7'b0010110, 7'b1111111};
   logic       par_tbl [16] = '{
      1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
      1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One isolated word: in_valid cycle, then inject applied while stage 1 is consumed.
   task automatic run_word(input logic [0:3] d, input logic [0:7] m,
                           input logic [0:3] ed, input logic e1, input logic e2);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.data_in  = d;
      bus.inject   = '0;
      @(negedge clk);
      check("code_valid", 32'(bus.code_valid), 32'd1);
      check("code_out", 32'(bus.code_out), 32'(code_tbl[d]));
      check("parity_out", 32'(bus.parity_out), 32'(par_tbl[d]));
      bus.in_valid = 1'b0;
      bus.inject   = m;
      @(negedge clk);
      if (e1 && exp_corr < 255) exp_corr++;
      if (e2 && exp_uncorr < 255) exp_uncorr++;
      check("out_valid", 32'(bus.out_valid), 32'd1);
      check("data_out", 32'(bus.data_out), 32'(ed));
      check("error_1bit", 32'(bus.error_1bit), 32'(e1));
      check("error_2bit", 32'(bus.error_2bit), 32'(e2));
      check("corr_count", 32'(bus.corr_count), 32'(exp_corr));
      check("uncorr_count", 32'(bus.uncorr_count), 32'(exp_uncorr));
      bus.inject = '0;
   endtask

   initial begin
      logic [0:7] mask;
      checks       = 0;
      errors       = 0;
      exp_corr     = 0;
      exp_uncorr   = 0;
      reset        = 1'b1;
      bus.in_valid = 1'b0;
      bus.data_in  = '0;
      bus.inject   = '0;
      repeat (3) @(negedge clk);
      check("rst_code_out", 32'(bus.code_out), 32'd0);
      check("rst_code_valid", 32'(bus.code_valid), 32'd0);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_data_out", 32'(bus.data_out), 32'd0);
      check("rst_corr", 32'(bus.corr_count), 32'd0);
      reset = 1'b0;

      for (int d = 0; d < 16; d++) run_word(4'(d), 8'h00, 4'(d), 1'b0, 1'b0);

      // Stage 2 idle: valid drops, data holds.
      @(negedge clk);
      check("idle_out_valid", 32'(bus.out_valid), 32'd0);
      check("idle_data_hold", 32'(bus.data_out), 32'd15);

      run_word(4'd2, 8'b00001000, 4'd2, 1'b1, 1'b0);
      run_word(4'd3, 8'b00000001, 4'd3, 1'b1, 1'b0);
      run_word(4'd1, 8'b11000000, 4'd1, 1'b0, 1'b1);

      for (int d = 0; d < 16; d++) begin
         for (int b = 0; b < 8; b++) begin
            mask = 8'h80 >> b;
            run_word(4'(d), mask, 4'(d), 1'b1, 1'b0);
         end
      end

      // Back-to-back stream with a permanent parity-bit flip.
      bus.inject = 8'b00000001;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (i >= 2) begin
            check("stream_valid", 32'(bus.out_valid), 32'd1);
            check("stream_data", 32'(bus.data_out), 32'((i - 2) % 16));
            check("stream_err1", 32'(bus.error_1bit), 32'd1);
         end
         bus.in_valid = 1'b1;
         bus.data_in  = 4'(i % 16);
      end
      @(negedge clk);
      check("corr_saturated", 32'(bus.corr_count), 32'd255);
      check("uncorr_held", 32'(bus.uncorr_count), 32'd1);

      // Reset while in_valid is still high.
      reset = 1'b1;
      @(negedge clk);
      check("mid_rst_code_valid", 32'(bus.code_valid), 32'd0);
      check("mid_rst_code_out", 32'(bus.code_out), 32'd0);
      check("mid_rst_parity", 32'(bus.parity_out), 32'd0);
      check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("mid_rst_data_out", 32'(bus.data_out), 32'd0);
      check("mid_rst_err1", 32'(bus.error_1bit), 32'd0);
      check("mid_rst_err2", 32'(bus.error_2bit), 32'd0);
      check("mid_rst_corr", 32'(bus.corr_count), 32'd0);
      check("mid_rst_uncorr", 32'(bus.uncorr_count), 32'd0);
      reset        = 1'b0;
      bus.in_valid = 1'b0;
      bus.inject   = '0;
      repeat (2) begin
         @(negedge clk);
         check("post_rst_code_valid", 32'(bus.code_valid), 32'd0);
         check("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
      end
      bus.in_valid = 1'b1;
      bus.data_in  = 4'd5;
      @(negedge clk);
      check("restart_code_valid", 32'(bus.code_valid), 32'd1);
      check("restart_code_out", 32'(bus.code_out), 32'(code_tbl[5]));
      check("restart_out_valid_early", 32'(bus.out_valid), 32'd0);
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("restart_out_valid", 32'(bus.out_valid), 32'd1);
      check("restart_data_out", 32'(bus.data_out), 32'd5);
      check("restart_err1", 32'(bus.error_1bit), 32'd0);
      check("restart_corr", 32'(bus.corr_count), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/hamming_secded_codec.md
# hamming_secded_codec

Registered Hamming(7,4) SECDED codec: encodes a 4-bit nibble into a 7-bit codeword plus an overall parity bit, passes it through an error-injection point, then decodes it. The decoder corrects single-bit errors and flags double-bit errors. It is the link-protection block between the data source and the channel/sink in the comm-system FPGA path; the injection port lets bring-up and test corrupt the channel deliberately.

## Interface
- No parameters; all widths are fixed.
- clk  in  1  single system clock, rising-edge.
- reset  in  1  synchronous, active-high; clears all registers.
- in_valid  in  1  data_in is accepted this cycle.
- data_in  in  [0:3]  nibble to encode; bit 0 is MSB (d0).
- inject  in  [0:7]  XOR error mask; [0:6] apply to the codeword, [7] to the parity bit.
- code_out  out  [0:6]  registered encoder codeword, pre-injection.
- parity_out  out  1  registered overall parity bit, pre-injection.
- code_valid  out  1  code_out/parity_out valid.
- data_out  out  [0:3]  decoded, corrected nibble.
- error_1bit  out  1  single-bit error detected and corrected (includes a parity-bit-only error).
- error_2bit  out  1  double-bit error detected; uncorrectable.
- out_valid  out  1  data_out/error flags valid.
- corr_count  out  8  saturating count of error_1bit events.
- uncorr_count  out  8  saturating count of error_2bit events.

## Operation
- Codeword bit c[i] sits at Hamming position i+1: c0=p1, c1=p2, c2=d0, c3=p4, c4=d1, c5=d2, c6=d3.
- p1 = d0^d1^d3; p2 = d0^d2^d3; p4 = d1^d2^d3.
- The parity bit is the XOR of c0..c6, so the 8 bits together have even parity.
- Channel: rc = code_reg ^ inject[0:6]; rp = parity_reg ^ inject[7]. This is combinational from the stage-1 register to the stage-2 register.
- Syndrome bits:
  - s1 = rc0^rc2^rc4^rc6
  - s2 = rc1^rc2^rc5^rc6
  - s4 = rc3^rc4^rc5^rc6
  - S = {s4,s2,s1}
  - Overall check: pc = XOR(rc0..rc6, rp).
- Decode cases:
  - S=0, pc=0: no error; data_out = {rc2,rc4,rc5,rc6}; both flags 0.
  - S≠0, pc=1: flip rc[S-1]; data_out comes from the corrected word; error_1bit=1.
  - S=0, pc=1: parity bit only in error; data_out uncorrected (already correct); error_1bit=1.
  - S≠0, pc=0: double error; data_out = uncorrected {rc2,rc4,rc5,rc6}; error_2bit=1.
- error_1bit and error_2bit are mutually exclusive.
- Triple or more errors are not detected reliably; no requirement applies to them.
- Counters:
  - Increment by 1 on each out_valid cycle with the corresponding flag set.
  - Saturate at 255.
  - Never wrap.

## Timing
- Stage 1 (encoder register): on a clk edge with in_valid=1, capture code_out/parity_out; code_valid=1 the next cycle.
- Stage 2 (decoder register): captures the decode of the stage-1 register (with the current inject) when code_valid=1.
- Latency:
  - data_in to code_out: 1 cycle.
  - data_in to data_out/flags: 2 cycles.
  - Throughput: 1 nibble per cycle, no backpressure.
- inject is sampled in the cycle the stage-1 word is consumed, i.e. one cycle after in_valid.
- When a stage is not valid, its registers hold their previous value and its valid output is 0. Flags update only on valid cycles.
- Reset values: code_out=0, parity_out=0, code_valid=0, data_out=0, error_1bit=0, error_2bit=0, out_valid=0, both counters 0.
- Reset asserted mid-stream:
  - In-flight words are discarded.
  - Reset wins over a simultaneous in_valid.
  - The first valid output after reset deassertion comes 2 cycles after the first accepted in_valid.

## Test plan
- Clean sweep:
  - data_in 0,1,2,3 with inject=0 give code_out/parity 0000000/0, 1101001/0, 0101010/1, 1000011/1.
  - data_out equals data_in 2 cycles later; flags 0.
  - Extend the sweep to all 16 values.
- Single codeword error: data_in=2, inject=00001000 (flips c4) → received 0101110, S=5, data_out=2, error_1bit=1, corr_count=1.
- Parity-bit-only error: data_in=3, inject=00000001 → data_out=3, error_1bit=1, error_2bit=0.
- Double error: data_in=1, inject=11000000 → error_2bit=1, error_1bit=0, uncorr_count increments.
- Exhaustive single-flip sweep: every nibble crossed with every single-bit inject (8 positions) → data_out always correct, error_1bit=1.
- Streaming and reset:
  - Back-to-back in_valid for 300 cycles with a single-bit inject: corr_count saturates at 255.
  - Reset asserted mid-stream: all outputs and counters read 0 the next cycle; out_valid stays 0 until 2 cycles after the next in_valid.
